risk_alarm_ctrl: RTL and testbench
==================================

RISK_ALARM_CTRL -- requirements
Module: risk_alarm_ctrl

Interface
REQ-001 Parameter MED_ON, default 40: average at or above this enters MED from LOW.
REQ-002 Parameter MED_OFF, default 35: average below this leaves MED or HIGH for LOW.
REQ-003 Parameter HIGH_ON, default 70: average at or above this enters HIGH.
REQ-004 Parameter HIGH_OFF, default 65: average below this leaves HIGH for MED, unless it is also below MED_OFF.
REQ-005 Parameter PERSIST, default 3, range 1..15: consecutive agreeing evaluations needed before a level change.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 risk_in  in  8  risk score from the fuzzy stage; valid range 0..100.
REQ-009 risk_valid  in  1  one-cycle strobe marking risk_in as a new sample.
REQ-010 ack  in  1  operator acknowledge, level-sensitive.
REQ-011 risk_avg  out  8  registered 4-sample moving average.
REQ-012 level  out  2  registered level: 0=LOW, 1=MED, 2=HIGH; 3 is never driven.
REQ-013 alarm  out  1  high exactly while level==HIGH.
REQ-014 alarm_latched  out  1  sticky alarm, cleared only by ack.

Function
REQ-015 A sample is accepted only in a cycle with risk_valid=1; with risk_valid=0 all state holds.
REQ-016 risk_in values above 100 are clamped to 100 before entering the window.
REQ-017 The window holds the 4 most recent accepted samples, zero after reset; the 10-bit sum is shifted right by 2 (truncating) to form risk_avg.
REQ-018 risk_avg updates on the cycle after acceptance (latency 1); a one-cycle internal eval strobe accompanies each update.
REQ-019 On each eval strobe, target is computed from current level and risk_avg as follows.
- LOW: HIGH if avg>=HIGH_ON, else MED if avg>=MED_ON, else LOW.
- MED: HIGH if avg>=HIGH_ON, else LOW if avg<MED_OFF, else MED.
- HIGH: LOW if avg<MED_OFF, else MED if avg<HIGH_OFF, else HIGH.
REQ-020 If target==level, the candidate counter clears to 0.
REQ-021 If target!=level and target==candidate with counter>0, the counter increments; otherwise candidate<=target and counter<=1.
REQ-022 When the counter reaches PERSIST, level<=candidate on that evaluation and the counter clears; level therefore changes 2 cycles after the deciding sample is accepted.
REQ-023 Direct LOW<->HIGH transitions are legal.
REQ-024 alarm_latched sets in the cycle level becomes HIGH.
REQ-025 ack clears alarm_latched only while level!=HIGH; ack is ignored while level==HIGH.
REQ-026 If set and ack occur in the same cycle, set wins.
REQ-027 The counter saturates and never wraps; PERSIST=1 gives an immediate change on the first disagreeing evaluation.

Reset
REQ-028 rst clears the window, risk_avg, level (LOW), candidate, counter, eval strobe, alarm and alarm_latched on the next edge, overriding any concurrent risk_valid or ack.
REQ-029 rst asserted mid-averaging or mid-persistence discards all history; the first sample after reset averages with three zeros.

Structure
REQ-030 Shared package risk_pkg holds the level encoding constants (LOW/MED/HIGH) and default threshold constants; the fuzzy stage and this block both import it.
REQ-031 Sub-module risk_avg4 implements clamp, 4-deep window and averaging (REQ-016..018); the classifier FSM and alarm latch live in risk_alarm_ctrl.

Verification
REQ-032 Reset: after reset, drive no samples -> risk_avg=0, level=0, alarm=0, alarm_latched=0.
REQ-033 Rise: after reset, six samples of 80 -> avg sequence 20,40,60,80,80,80.
- Candidate goes MED,MED, then restarts at HIGH.
- level=HIGH 2 cycles after the 6th sample, never MED.
- alarm=1 and alarm_latched=1.
REQ-034 Clamp: four samples of 200 -> risk_avg=100.
REQ-035 Hysteresis: at MED, avg 37 for 5 evaluations -> stays MED; then avg 34 for 3 evaluations -> LOW after the 3rd.
REQ-036 Ack: ack held while HIGH -> alarm_latched stays 1. Drop to MED, then pulse ack -> alarm_latched=0. ack in the same cycle as re-entry to HIGH -> alarm_latched=1.
REQ-037 Mid-reset: rst after two of three persistence samples toward HIGH -> level stays LOW, window zeroed; the next sample of 80 gives risk_avg=20.

Source files
------------

// File: rtl/risk_pkg.sv
// Shared risk-score definitions: level encoding and default alarm thresholds.
package risk_pkg;

  typedef enum logic [1:0] {
    LvlLow  = 2'd0,
    LvlMed  = 2'd1,
    LvlHigh = 2'd2
  } risk_level_e;

  localparam int unsigned MedOnDef   = 40;
  localparam int unsigned MedOffDef  = 35;
  localparam int unsigned HighOnDef  = 70;
  localparam int unsigned HighOffDef = 65;
  localparam int unsigned PersistDef = 3;
  localparam int unsigned RiskMax    = 100;

endpackage

// File: rtl/risk_avg4.sv
// Clamps incoming risk samples and keeps a registered 4-sample moving average,
// raising a one-cycle eval strobe alongside every average update.
module risk_avg4
  import risk_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] risk_i,
  input  logic       risk_valid_i,
  output logic [7:0] risk_avg_o,
  output logic       eval_o
);

  logic [7:0]       sample_clamped;
  logic [3:0][7:0]  win_q;
  logic [9:0]       sum_new;
  logic [7:0]       avg_q;
  logic             eval_q;

  assign sample_clamped = (risk_i > 8'(RiskMax)) ? 8'(RiskMax) : risk_i;

  // Average over the window as it will look after the new sample is shifted in.
  assign sum_new = 10'(sample_clamped) + 10'(win_q[0]) + 10'(win_q[1]) + 10'(win_q[2]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      win_q  <= '0;
      avg_q  <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= risk_valid_i;
      if (risk_valid_i) begin
        win_q <= {win_q[2:0], sample_clamped};
        avg_q <= sum_new[9:2];
      end
    end
  end

  assign risk_avg_o = avg_q;
  assign eval_o     = eval_q;

endmodule

// File: rtl/risk_alarm_ctrl.sv
// Hysteretic LOW/MED/HIGH risk classifier with persistence filtering and a
// sticky operator-acknowledged alarm.
module risk_alarm_ctrl
  import risk_pkg::*;
#(
  parameter int unsigned MED_ON   = MedOnDef,
  parameter int unsigned MED_OFF  = MedOffDef,
  parameter int unsigned HIGH_ON  = HighOnDef,
  parameter int unsigned HIGH_OFF = HighOffDef,
  parameter int unsigned PERSIST  = PersistDef
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] risk_in,
  input  logic       risk_valid,
  input  logic       ack,
  output logic [7:0] risk_avg,
  output logic [1:0] level,
  output logic       alarm,
  output logic       alarm_latched
);

  localparam logic [7:0] MedOn   = 8'(MED_ON);
  localparam logic [7:0] MedOff  = 8'(MED_OFF);
  localparam logic [7:0] HighOn  = 8'(HIGH_ON);
  localparam logic [7:0] HighOff = 8'(HIGH_OFF);
  localparam logic [3:0] Persist = 4'(PERSIST);

  logic [7:0]  avg;
  logic        eval;

  risk_level_e level_q, level_d;
  risk_level_e cand_q, cand_d;
  risk_level_e target;
  logic [3:0]  cnt_q, cnt_d, cnt_step;
  logic        latched_q, latched_d;
  logic        alarm_q;

  risk_avg4 u_avg (
    .clk_i        (clk),
    .rst_i        (rst),
    .risk_i       (risk_in),
    .risk_valid_i (risk_valid),
    .risk_avg_o   (avg),
    .eval_o       (eval)
  );

  always_comb begin
    target = LvlLow;
    unique case (level_q)
      LvlLow: begin
        if (avg >= HighOn)     target = LvlHigh;
        else if (avg >= MedOn) target = LvlMed;
        else                   target = LvlLow;
      end
      LvlMed: begin
        if (avg >= HighOn)     target = LvlHigh;
        else if (avg < MedOff) target = LvlLow;
        else                   target = LvlMed;
      end
      LvlHigh: begin
        if (avg < MedOff)       target = LvlLow;
        else if (avg < HighOff) target = LvlMed;
        else                    target = LvlHigh;
      end
      default: target = LvlLow;
    endcase
  end

  always_comb begin
    level_d   = level_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    cnt_step  = '0;
    latched_d = latched_q;

    if (eval) begin
      if (target == level_q) begin
        cnt_d = '0;
      end else begin
        if (target == cand_q && cnt_q != 4'd0) begin
          cnt_step = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        end else begin
          cand_d   = target;
          cnt_step = 4'd1;
        end
        if (cnt_step >= Persist) begin
          level_d = target;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_step;
        end
      end
    end

    // Entering or staying HIGH dominates any acknowledge in the same cycle.
    if (level_d == LvlHigh) begin
      latched_d = 1'b1;
    end else if (ack && level_q != LvlHigh) begin
      latched_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= LvlLow;
      cand_q    <= LvlLow;
      cnt_q     <= '0;
      latched_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      latched_q <= latched_d;
      alarm_q   <= (level_d == LvlHigh);
    end
  end

  assign risk_avg      = avg;
  assign level         = level_q;
  assign alarm         = alarm_q;
  assign alarm_latched = latched_q;

endmodule

// File: tb/tb_risk_alarm_ctrl.sv
// Directed and randomized checks of risk_alarm_ctrl against a cycle-level reference model.
module tb_risk_alarm_ctrl;

  localparam int MedOnM   = 40;
  localparam int MedOffM  = 35;
  localparam int HighOnM  = 70;
  localparam int HighOffM = 65;
  localparam int PersistM = 3;

  logic       clk;
  logic       rst;
  logic [7:0] risk_in;
  logic       risk_valid;
  logic       ack;
  logic [7:0] risk_avg;
  logic [1:0] level;
  logic       alarm;
  logic       alarm_latched;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int win[$] = '{0, 0, 0, 0};
  int m_avg   = 0;
  bit m_pend  = 0;
  int m_lvl   = 0;
  int m_cand  = 0;
  int m_cnt   = 0;
  bit m_latch = 0;

  risk_alarm_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .risk_in       (risk_in),
    .risk_valid    (risk_valid),
    .ack           (ack),
    .risk_avg      (risk_avg),
    .level         (level),
    .alarm         (alarm),
    .alarm_latched (alarm_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int target_of(input int lvl, input int avg);
    if (lvl == 0) return (avg >= HighOnM) ? 2 : (avg >= MedOnM) ? 1 : 0;
    if (lvl == 1) return (avg >= HighOnM) ? 2 : (avg < MedOffM) ? 0 : 1;
    return (avg < MedOffM) ? 0 : (avg < HighOffM) ? 1 : 2;
  endfunction

  task automatic model_step(input bit v, input int d, input bit a, input bit r);
    int old_lvl;
    int tgt;
    int s;
    if (r) begin
      win = '{0, 0, 0, 0};
      m_avg = 0; m_pend = 0; m_lvl = 0; m_cand = 0; m_cnt = 0; m_latch = 0;
      return;
    end
    old_lvl = m_lvl;
    if (m_pend) begin
      tgt = target_of(m_lvl, m_avg);
      if (tgt == m_lvl) begin
        m_cnt = 0;
      end else begin
        if (tgt == m_cand && m_cnt > 0) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else begin
          m_cand = tgt;
          m_cnt  = 1;
        end
        if (m_cnt >= PersistM) begin
          m_lvl = tgt;
          m_cnt = 0;
        end
      end
    end
    m_pend = 0;
    if (m_lvl == 2) m_latch = 1;
    else if (a && old_lvl != 2) m_latch = 0;
    if (v) begin
      win.push_front((d > 100) ? 100 : d);
      void'(win.pop_back());
      s = 0;
      foreach (win[i]) s += win[i];
      m_avg  = s / 4;
      m_pend = 1;
    end
  endtask

  // Drive one cycle from the falling edge, step the model at the rising edge, compare #1 later.
  task automatic cyc(input bit v, input int d, input bit a, input bit r);
    risk_valid = v;
    risk_in    = 8'(d);
    ack        = a;
    rst        = r;
    @(posedge clk);
    model_step(v, d, a, r);
    #1;
    check_eq("avg", risk_avg, m_avg);
    check_eq("level", level, m_lvl);
    check_eq("alarm", alarm, (m_lvl == 2) ? 1 : 0);
    check_eq("latched", alarm_latched, m_latch);
    @(negedge clk);
  endtask

  initial begin
    int rise_exp[6] = '{20, 40, 60, 80, 80, 80};
    int base;
    int d;
    rst = 1'b1; risk_valid = 1'b0; risk_in = '0; ack = 1'b0;
    @(negedge clk);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Reset state with no samples
    cyc(0, 0, 0, 0);
    check_eq("rst_avg", risk_avg, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_alarm", alarm, 0);
    check_eq("rst_latched", alarm_latched, 0);

    // Rise: six samples of 80, straight LOW->HIGH
    for (int i = 0; i < 6; i++) begin
      cyc(1, 80, 0, 0);
      check_eq("rise_avg", risk_avg, rise_exp[i]);
      check_eq("rise_not_med", (level == 2'd1) ? 1 : 0, 0);
    end
    check_eq("rise_pre_level", level, 0);
    cyc(0, 0, 0, 0);
    check_eq("rise_level", level, 2);
    check_eq("rise_alarm", alarm, 1);
    check_eq("rise_latched", alarm_latched, 1);

    // Ack held while HIGH is ignored
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    check_eq("ack_high_latched", alarm_latched, 1);
    // Drop to MED, latch persists until ack
    for (int i = 0; i < 6; i++) cyc(1, 50, 0, 0);
    cyc(0, 0, 0, 0);
    check_eq("drop_level", level, 1);
    check_eq("drop_alarm", alarm, 0);
    check_eq("drop_latched", alarm_latched, 1);
    cyc(0, 0, 1, 0);
    check_eq("ack_med_latched", alarm_latched, 0);
    // Re-enter HIGH with ack held: set wins
    for (int i = 0; i < 5; i++) cyc(1, 80, 1, 0);
    cyc(0, 0, 1, 0);
    check_eq("reenter_level", level, 2);
    check_eq("reenter_latched", alarm_latched, 1);

    // Clamp
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 200, 0, 0);
    check_eq("clamp_avg", risk_avg, 100);

    // Hysteresis around MED_OFF
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 50, 0, 0);
    cyc(0, 0, 0, 0);
    check_eq("hyst_med", level, 1);
    for (int i = 0; i < 9; i++) cyc(1, 37, 0, 0);
    cyc(0, 0, 0, 0);
    check_eq("hyst_avg37", risk_avg, 37);
    check_eq("hyst_stay_med", level, 1);
    for (int i = 0; i < 5; i++) cyc(1, 34, 0, 0);
    check_eq("hyst_two_low", level, 1);
    cyc(0, 0, 0, 0);
    check_eq("hyst_low", level, 0);

    // Reset in the middle of persistence toward HIGH
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 80, 0, 0);
    cyc(0, 0, 0, 1);
    check_eq("midrst_avg", risk_avg, 0);
    check_eq("midrst_level", level, 0);
    cyc(1, 80, 0, 0);
    check_eq("midrst_first_avg", risk_avg, 20);
    cyc(0, 0, 0, 0);
    check_eq("midrst_stay_low", level, 0);

    // Randomized traffic with a drifting operating point
    base = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) base = 10 * $urandom_range(0, 10);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : base + $urandom_range(0, 15);
      cyc($urandom_range(0, 1) == 1, d, $urandom_range(0, 4) == 0, $urandom_range(0, 149) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
